spi_reg_bank: RTL and testbench

- Parametrised SPI slave register bank, successor to the single-register SPI control slave.
- Holds NREG writable and readable registers of NBIT bits behind one 7-bit base address window.
- Oversamples sclk/mosi/cs in the clk domain and exposes all registers as a flat control bus, with per-register write strobes.
- Sits on the shared board SPI bus next to other slaves; miso is released whenever the frame is not addressed to this block.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_bank.sv | 218 +++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: address field layout, frame state encoding
// and a constant clog2 helper.
package spi_pkg;

    localparam int unsigned SPI_ADR_W  = 7;
    localparam int unsigned SPI_RW_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        SKIP
    } spi_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop for
// rise/fall detection on the synchronised level.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing NREG registers of NBIT bits at BASE_ADR..BASE_ADR+NREG-1.
// Define SPI_REG_BANK_AUTOINC_EN for burst access with auto-incrementing index.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int unsigned     NBIT      = 16,
    parameter int unsigned     NREG      = 4,
    parameter logic [6:0]      BASE_ADR  = 7'h01,
    parameter logic [NBIT-1:0] RESET_VAL = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 cs,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [NREG*NBIT-1:0] regs,
    output logic [NREG-1:0]      wr_stb
);

    // Counter also has to reach 8 for the address byte when NBIT < 8.
    localparam int unsigned CNT_W = clog2((NBIT > 8) ? NBIT : 8) + 1;
    localparam int unsigned IDX_W = (NREG > 1) ? clog2(NREG) : 1;

    localparam logic [CNT_W-1:0] CNT_ADR       = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_ADR_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_WORD_LAST = CNT_W'(NBIT - 1);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_s;
    logic mosi_s;
    logic unused_sclk_level;
    logic unused_cs_rise;
    logic unused_cs_fall;
    logic unused_mosi_rise;
    logic unused_mosi_fall;

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk),
        .level_o (unused_sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs),
        .level_o (cs_s),
        .rise_o  (unused_cs_rise),
        .fall_o  (unused_cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .d_i     (mosi),
        .level_o (mosi_s),
        .rise_o  (unused_mosi_rise),
        .fall_o  (unused_mosi_fall)
    );

    spi_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SPI_ADR_W-1:0] adr_sh_q;
    logic [NBIT-1:0]      shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 rw_q;
    logic                 hit_q;
    logic                 wr_pend_q;
    logic [IDX_W-1:0]     wr_idx_q;
    logic                 miso_oe_q;
    logic [NREG-1:0]      wr_stb_q;
    logic [NBIT-1:0]      regs_q [NREG];

    logic [7:0]           adr_byte_d;
    logic [SPI_ADR_W-1:0] adr_off_d;
    logic                 adr_hit_d;

    assign adr_byte_d = {adr_sh_q, mosi_s};
    assign adr_off_d  = adr_byte_d[SPI_ADR_W-1:0] - BASE_ADR;
    assign adr_hit_d  = (32'(adr_off_d) < NREG);

`ifdef SPI_REG_BANK_AUTOINC_EN
    logic             idx_last_d;
    logic [IDX_W-1:0] idx_inc_d;

    assign idx_last_d = ((32'(idx_q) + 32'd1) == NREG);
    assign idx_inc_d  = idx_q + IDX_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_sh_q  <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            rw_q      <= 1'b0;
            hit_q     <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            miso_oe_q <= 1'b0;
            wr_stb_q  <= '0;
            for (int unsigned k = 0; k < NREG; k++) regs_q[k] <= RESET_VAL;
        end else begin
            wr_stb_q  <= '0;
            wr_pend_q <= 1'b0;
            // A completed word commits one clk after its last rise, even if cs rises meanwhile.
            if (wr_pend_q) begin
                regs_q[wr_idx_q]   <= shift_q;
                wr_stb_q[wr_idx_q] <= 1'b1;
            end

            if (cs_s) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ADDR;
                        cnt_q   <= '0;
                    end

                    // Dispatch waits for the 8th fall so the first read bit is not shifted away.
                    ADDR: begin
                        if (sclk_rise && cnt_q != CNT_ADR) begin
                            adr_sh_q <= {adr_sh_q[SPI_ADR_W-2:0], mosi_s};
                            cnt_q    <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_ADR_LAST) begin
                                rw_q  <= adr_byte_d[SPI_RW_BIT];
                                hit_q <= adr_hit_d;
                                idx_q <= adr_off_d[IDX_W-1:0];
                            end
                        end else if (sclk_fall && cnt_q == CNT_ADR) begin
                            cnt_q <= '0;
                            if (!hit_q) begin
                                state_q <= SKIP;
                            end else if (rw_q) begin
                                state_q <= WDATA;
                            end else begin
                                state_q   <= RDATA;
                                shift_q   <= regs_q[idx_q];
                                miso_oe_q <= 1'b1;
                            end
                        end
                    end

                    WDATA: begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[NBIT-2:0], mosi_s};
                            if (cnt_q == CNT_WORD_LAST) begin
                                cnt_q     <= '0;
                                wr_pend_q <= 1'b1;
                                wr_idx_q  <= idx_q;
`ifdef SPI_REG_BANK_AUTOINC_EN
                                if (idx_last_d) state_q <= SKIP;
                                else            idx_q   <= idx_inc_d;
`else
                                state_q <= SKIP;
`endif
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    RDATA: begin
                        if (sclk_fall) begin
                            if (cnt_q == CNT_WORD_LAST) begin
                                cnt_q <= '0;
`ifdef SPI_REG_BANK_AUTOINC_EN
                                if (idx_last_d) begin
                                    state_q   <= SKIP;
                                    miso_oe_q <= 1'b0;
                                end else begin
                                    idx_q   <= idx_inc_d;
                                    shift_q <= regs_q[idx_inc_d];
                                end
`else
                                state_q   <= SKIP;
                                miso_oe_q <= 1'b0;
`endif
                            end else begin
                                shift_q <= {shift_q[NBIT-2:0], 1'b0};
                                cnt_q   <= cnt_q + CNT_W'(1);
                            end
                        end
                    end

                    SKIP: begin
                        miso_oe_q <= 1'b0;
                    end

                    default: begin
                        state_q   <= IDLE;
                        miso_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        regs = '0;
        for (int unsigned k = 0; k < NREG; k++) regs[k*NBIT +: NBIT] = regs_q[k];
    end

    assign miso_oe = miso_oe_q;
    assign miso    = miso_oe_q ? shift_q[NBIT-1] : 1'b1;
    assign wr_stb  = wr_stb_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomised self-checking bench for spi_reg_bank against a frame-level model.
module tb_spi_reg_bank;

    localparam int         NBIT = 16;
    localparam int         NREG = 4;
    localparam logic [6:0] BASE = 7'h01;
    localparam int         HALF = 40;
`ifdef SPI_REG_BANK_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 sclk;
    logic                 mosi;
    logic                 cs;
    logic                 miso;
    logic                 miso_oe;
    logic [NREG*NBIT-1:0] regs;
    logic [NREG-1:0]      wr_stb;

    spi_reg_bank #(
        .NBIT      (NBIT),
        .NREG      (NREG),
        .BASE_ADR  (BASE),
        .RESET_VAL (16'hFFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs      (cs),
        .miso    (miso),
        .miso_oe (miso_oe),
        .regs    (regs),
        .wr_stb  (wr_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int stb_cnt [NREG];
    int exp_stb [NREG];
    logic [NBIT-1:0] mdl [NREG];
    logic [NBIT-1:0] tx_words [4];
    logic rx_miso [$];
    logic rx_oe   [$];

    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++)
            if (wr_stb[k] === 1'b1) stb_cnt[k]++;
    end

    task automatic sclk_bit(input logic b);
        mosi = b;
        #HALF;
        sclk = 1'b1;
        rx_miso.push_back(miso);
        rx_oe.push_back(miso_oe);
        #HALF;
        sclk = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < NREG; k++) begin
            chk($sformatf("%s_reg%0d", tag, k), 32'(regs[k*NBIT +: NBIT]), 32'(mdl[k]));
            chk($sformatf("%s_stb%0d", tag, k), 32'(stb_cnt[k]), 32'(exp_stb[k]));
        end
    endtask

    // Frame-level expectation: words addressed past the window or beyond the first
    // (unless bursting) are ignored; only whole words are ever written.
    task automatic model_check(input logic [7:0] ab, input int ndata, input string tag);
        logic [6:0] off;
        int         offi;
        bit         hit;
        bit         rw;
        logic [7:0] aoe;
        off  = ab[6:0] - BASE;
        offi = int'(off);
        hit  = offi < NREG;
        rw   = ab[7];
        for (int i = 0; i < 8; i++) aoe[7-i] = rx_oe[i];
        chk({tag, "_addr_oe"}, 32'(aoe), 32'd0);
        for (int w = 0; w * NBIT < ndata; w++) begin
            int         nb;
            bit         active;
            logic [31:0] obs_m, obs_o, exp_m, exp_o, ones;
            nb     = (ndata - w * NBIT > NBIT) ? NBIT : ndata - w * NBIT;
            active = hit && (w == 0 || AUTOINC) && (offi + w < NREG);
            obs_m  = '0;
            obs_o  = '0;
            for (int b = 0; b < nb; b++) begin
                obs_m = {obs_m[30:0], rx_miso[8 + w*NBIT + b]};
                obs_o = {obs_o[30:0], rx_oe[8 + w*NBIT + b]};
            end
            ones = (32'd1 << nb) - 32'd1;
            if (!rw && active) begin
                exp_o = ones;
                exp_m = 32'(mdl[offi + w]) >> (NBIT - nb);
            end else begin
                exp_o = '0;
                exp_m = ones;
            end
            chk($sformatf("%s_w%0d_miso", tag, w), obs_m, exp_m);
            chk($sformatf("%s_w%0d_oe", tag, w), obs_o, exp_o);
            if (rw && active && nb == NBIT) begin
                mdl[offi + w] = tx_words[w];
                exp_stb[offi + w]++;
            end
        end
        check_state(tag);
        chk({tag, "_idle_oe"}, 32'(miso_oe), 32'd0);
        chk({tag, "_idle_miso"}, 32'(miso), 32'd1);
    endtask

    task automatic frame(input logic [7:0] ab, input int ndata, input string tag);
        rx_miso.delete();
        rx_oe.delete();
        cs = 1'b0;
        #HALF;
        for (int i = 7; i >= 0; i--) sclk_bit(ab[i]);
        for (int j = 0; j < ndata; j++) sclk_bit(tx_words[j / NBIT][NBIT - 1 - (j % NBIT)]);
        #HALF;
        cs = 1'b1;
        #(HALF * 3);
        model_check(ab, ndata, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ab;
        int         nd;
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs   = 1'b1;
        for (int k = 0; k < NREG; k++) begin
            mdl[k]     = 16'hFFFF;
            exp_stb[k] = 0;
            stb_cnt[k] = 0;
        end
        repeat (5) @(posedge clk);
        #2;
        check_state("reset");
        chk("reset_oe", 32'(miso_oe), 32'd0);
        chk("reset_miso", 32'(miso), 32'd1);
        chk("reset_wr_stb", 32'(wr_stb), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        tx_words[0] = 16'h1234;
        frame(8'h81, NBIT, "wr_r0");
        chk("wr_r0_direct", 32'(regs[15:0]), 32'h1234);

        tx_words[0] = 16'hA5C3;
        frame(8'h82, NBIT, "wr_r1");
        frame(8'h02, NBIT, "rd_r1");

        tx_words[0] = 16'h0000;
        frame(8'hFF, NBIT, "wr_out");

        tx_words[0] = 16'h5A5A;
        frame(8'h83, 9, "abort_r2");
        tx_words[0] = 16'h0F0F;
        frame(8'h83, NBIT, "after_abort");

        tx_words[0] = 16'h1111;
        tx_words[1] = 16'h2222;
        tx_words[2] = 16'h3333;
        frame(8'h83, 3 * NBIT, "burst_wr");
        frame(8'h03, 3 * NBIT, "burst_rd");

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 5))
                0:       ab = {1'($urandom), 7'h7F};
                1:       ab = {1'($urandom), 7'h00};
                default: ab = {1'($urandom), 7'($urandom_range(1, NREG + 1))};
            endcase
            if ($urandom_range(0, 1) == 1) nd = $urandom_range(1, 3) * NBIT;
            else                          nd = $urandom_range(0, 56);
            for (int w = 0; w < 4; w++) tx_words[w] = 16'($urandom);
            frame(ab, nd, $sformatf("rnd%0d", n));
        end

        rx_miso.delete();
        rx_oe.delete();
        cs = 1'b0;
        #HALF;
        for (int i = 7; i >= 0; i--) sclk_bit(ab[i] ^ ab[i] ^ ((8'h02 >> i) & 1'b1));
        for (int j = 0; j < 5; j++) sclk_bit(1'b0);
        #HALF;
        chk("rst_mid_oe_before", 32'(miso_oe), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREG; k++) mdl[k] = 16'hFFFF;
        chk("rst_mid_oe", 32'(miso_oe), 32'd0);
        chk("rst_mid_miso", 32'(miso), 32'd1);
        check_state("rst_mid");
        #1;
        rst = 1'b0;
        cs  = 1'b1;
        #(HALF * 3);

        tx_words[0] = 16'hBEEF;
        frame(8'h84, NBIT, "post_rst_wr");
        frame(8'h04, NBIT, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
